// File: rtl/fetch_queue_pkg.sv
// Shared types for the instruction prefetch queue.
// Holds the controller state encoding, the default halt opcode and the
// FIFO entry layout {ir, pc4} used by the top and by fetchq_fifo.
package fetch_queue_pkg;

    typedef enum logic [1:0] {
        ST_FETCH  = 2'd0,
        ST_SQUASH = 2'd1,
        ST_HALT   = 2'd2
    } fq_state_t;

    localparam logic [5:0] HALT_OP_DEF = 6'b111111;

    typedef struct packed {
        logic [31:0] ir;
        logic [31:0] pc4;
    } fetch_entry_t;

endpackage

// File: rtl/fetchq_fifo.sv
// Purpose: synchronous DEPTH x 64 FIFO of fetch entries with clear.
// Latency: push visible at head one cycle after the write edge.
// Backpressure: none internally; the caller reserves space before pushing.
// Ports: clk/rst (async active-high), push/push_dat, pop, clear (wins over
// push/pop), head_dat (raw head slot, caller masks when empty), count.
module fetchq_fifo
    import fetch_queue_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  fetch_entry_t  push_dat,
    input  logic          pop,
    input  logic          clear,
    output fetch_entry_t  head_dat,
    output logic [CW-1:0] count
);

    fetch_entry_t  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset; stale slots are never presented as valid.
    always_ff @(posedge clk) begin
        if (push && !clear) mem[wr_ptr] <= push_dat;
    end

    assign head_dat = mem[rd_ptr];

endmodule

// File: rtl/fetch_queue.sv
// Purpose: instruction prefetch queue feeding ID with {ir, pc4}; handles
// redirects (squashing an in-flight fetch) and stops fetching after HALT_OP.
// Latency: ack-to-ID 1 cycle; 0 cycles when FETCHQ_BYPASS_EN is defined.
// Backpressure: id_ready low holds the head; fetching stops when the FIFO is full.
// Ports: clk, rst (async active-high); redirect/redirect_pc from branch
// resolution; mem_req/mem_addr/mem_ack/mem_rdata to instruction memory;
// id_valid/id_ready/id_ir/id_pc4 to ID; halted status.
// Optional macro FETCHQ_BYPASS_EN: empty-FIFO acks go straight to ID.
module fetch_queue
    import fetch_queue_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [5:0]  HALT_OP  = HALT_OP_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        id_valid,
    input  logic        id_ready,
    output logic [31:0] id_ir,
    output logic [31:0] id_pc4,
    output logic        halted
);

    localparam int            CW      = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    fq_state_t     state, state_nxt;
    logic [31:0]   fetch_pc;
    logic [31:0]   squash_pc;
    logic [31:0]   pc4;
    logic [CW-1:0] count;
    fetch_entry_t  head;
    fetch_entry_t  push_dat;
    logic          fifo_empty;
    logic          ack;
    logic          accept;
    logic          is_halt;
    logic          bypass;
    logic          push;
    logic          pop;

    assign pc4        = fetch_pc + 32'd4;
    assign fifo_empty = (count == '0);
    assign is_halt    = (mem_rdata[31:26] == HALT_OP);

    // Space is checked per request; count can only grow on an ack, so a
    // raised request stays raised (and its address stable) until acked.
    assign mem_req  = !rst && (((state == ST_FETCH) && (count < DEPTH_C)) ||
                               (state == ST_SQUASH));
    assign mem_addr = (state == ST_SQUASH) ? squash_pc : fetch_pc;

    assign ack    = mem_req && mem_ack;
    // A word belongs to the program stream only if it was fetched in FETCH
    // and is not being flushed by a same-cycle redirect.
    assign accept = ack && (state == ST_FETCH) && !redirect;

`ifdef FETCHQ_BYPASS_EN
    assign bypass = accept && fifo_empty;
`else
    assign bypass = 1'b0;
`endif

    assign push     = accept && !(bypass && id_ready);
    assign pop      = !fifo_empty && !redirect && id_ready;
    assign push_dat = '{ir: mem_rdata, pc4: pc4};
    assign halted   = (state == ST_HALT);

    fetchq_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (push),
        .push_dat (push_dat),
        .pop      (pop),
        .clear    (redirect),
        .head_dat (head),
        .count    (count)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_FETCH;
        else     state <= state_nxt;
    end

    // Redirect wins in every state. If a request is outstanding and not
    // acked, the handshake must finish on the old address, so go to SQUASH.
    always_comb begin
        state_nxt = state;
        if (redirect) begin
            state_nxt = (mem_req && !mem_ack) ? ST_SQUASH : ST_FETCH;
        end else begin
            case (state)
                ST_FETCH:  if (accept && is_halt) state_nxt = ST_HALT;
                ST_SQUASH: if (mem_ack) state_nxt = ST_FETCH;
                default:   state_nxt = state;
            endcase
        end
    end

    always_comb begin
        id_valid = 1'b0;
        id_ir    = 32'd0;
        id_pc4   = 32'd0;
        if (!fifo_empty) begin
            id_valid = !redirect;
            id_ir    = head.ir;
            id_pc4   = head.pc4;
        end else if (bypass) begin
            id_valid = 1'b1;
            id_ir    = mem_rdata;
            id_pc4   = pc4;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc  <= RESET_PC;
            squash_pc <= RESET_PC;
        end else begin
            if (redirect)    fetch_pc <= redirect_pc;
            else if (accept) fetch_pc <= pc4;
            if (redirect && mem_req && !mem_ack) squash_pc <= mem_addr;
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: a variable-latency instruction memory responder and
// a program-order reference model (next expected pc) checking every word ID
// accepts, plus directed scenarios for backpressure, redirect, halt and reset.
module tb_fetch_queue;

    logic        clk, rst, redirect, mem_req, mem_ack, id_valid, id_ready, halted;
    logic [31:0] redirect_pc, mem_addr, mem_rdata, id_ir, id_pc4;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          lat_min  = 0;
    int          lat_max  = 0;
    logic [31:0] spec_addr = 32'h1;
    logic [31:0] spec_word = 32'h0;
    logic [31:0] exp_pc;

    // Sampled view of one cycle, taken between the negedge and the posedge.
    logic        s_valid, s_req, s_ack, s_halted, fire;
    logic [31:0] s_ir, s_pc4, s_addr;

    fetch_queue dut (
        .clk(clk), .rst(rst), .redirect(redirect), .redirect_pc(redirect_pc),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .id_valid(id_valid), .id_ready(id_ready), .id_ir(id_ir), .id_pc4(id_pc4),
        .halted(halted)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] imem(input logic [31:0] a);
        if (a == spec_addr) return spec_word;
        return {6'b000010, a[25:0] ^ 26'h15A5A5A};
    endfunction

    // Memory: a request seen at negedge is acked after a random wait of
    // lat_min..lat_max cycles (0 = same cycle as the request).
    initial begin
        int mw;
        int cur_lat;
        mw = 0; cur_lat = 0; mem_ack = 1'b0; mem_rdata = 32'd0;
        forever begin
            @(negedge clk);
            if (mem_req && !rst) begin
                if (mw == 0) cur_lat = $urandom_range(lat_max, lat_min);
                if (mw >= cur_lat) begin
                    mem_ack = 1'b1; mem_rdata = imem(mem_addr); mw = 0;
                end else begin
                    mem_ack = 1'b0; mem_rdata = $urandom; mw++;
                end
            end else begin
                mem_ack = 1'b0; mem_rdata = $urandom; mw = 0;
            end
        end
    end

    task automatic tick(input logic rdy, input logic rd, input logic [31:0] rpc);
        @(negedge clk); #1;
        id_ready = rdy; redirect = rd; redirect_pc = rpc;
        #1;
        s_valid = id_valid; s_ir = id_ir; s_pc4 = id_pc4; s_halted = halted;
        s_req = mem_req; s_addr = mem_addr; s_ack = mem_ack && mem_req;
        fire = id_valid && rdy;
    endtask

    task automatic do_reset();
        @(negedge clk); #1;
        rst = 1'b1; redirect = 1'b0; id_ready = 1'b0;
        @(negedge clk); #1;
        rst = 1'b0;
        exp_pc = 32'h0;
        spec_addr = 32'h1;
    endtask

    task automatic test_reset();
        #2;
        n_checks++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL reset_mem_req got %b want 0", mem_req); end
        n_checks++; if (id_valid !== 1'b0) begin n_fail++; $display("FAIL reset_id_valid got %b want 0", id_valid); end
        n_checks++; if (id_ir !== 32'h0) begin n_fail++; $display("FAIL reset_id_ir got %h want 0", id_ir); end
        n_checks++; if (id_pc4 !== 32'h0) begin n_fail++; $display("FAIL reset_id_pc4 got %h want 0", id_pc4); end
        n_checks++; if (halted !== 1'b0) begin n_fail++; $display("FAIL reset_halted got %b want 0", halted); end
        @(negedge clk); #1;
        rst = 1'b0; exp_pc = 32'h0;
        tick(1'b0, 1'b0, 32'h0);
        n_checks++; if (s_req !== 1'b1 || s_addr !== 32'h0) begin n_fail++; $display("FAIL reset_first_req got req=%b addr=%h want 1/00000000", s_req, s_addr); end
    endtask

    task automatic test_stream();
        do_reset();
        lat_min = 0; lat_max = 0;
        for (int i = 0; i < 20; i++) begin
            tick(1'b1, 1'b0, 32'h0);
            n_checks++; if (s_req !== 1'b1 || s_addr !== 32'(4 * i)) begin n_fail++; $display("FAIL stream_addr cyc %0d got req=%b addr=%h want 1/%h", i, s_req, s_addr, 32'(4 * i)); end
            if (i >= 1) begin
                n_checks++; if (fire !== 1'b1) begin n_fail++; $display("FAIL stream_rate cyc %0d got valid=%b want 1", i, s_valid); end
            end
            if (fire) begin
                n_checks++; if (s_ir !== imem(exp_pc) || s_pc4 !== exp_pc + 32'd4) begin n_fail++; $display("FAIL stream_data got %h/%h want %h/%h", s_ir, s_pc4, imem(exp_pc), exp_pc + 32'd4); end
                exp_pc += 32'd4;
            end
        end
    endtask

    task automatic test_backpressure();
        int acks, fires;
        logic got;
        logic [31:0] raddr;
        do_reset();
        lat_min = 3; lat_max = 3; acks = 0;
        for (int i = 0; i < 40; i++) begin
            tick(1'b0, 1'b0, 32'h0);
            if (s_ack) acks++;
        end
        n_checks++; if (acks !== 4) begin n_fail++; $display("FAIL bp_acks got %0d want 4", acks); end
        n_checks++; if (s_req !== 1'b0) begin n_fail++; $display("FAIL bp_full_req got %b want 0", s_req); end
        fires = 0; got = 1'b0; raddr = 32'h0;
        for (int i = 0; i < 30 && !(fires == 4 && got); i++) begin
            tick(1'b1, 1'b0, 32'h0);
            if (s_req && !got) begin got = 1'b1; raddr = s_addr; end
            if (fire) begin
                fires++;
                n_checks++; if (s_ir !== imem(exp_pc) || s_pc4 !== exp_pc + 32'd4) begin n_fail++; $display("FAIL bp_data got %h/%h want %h/%h", s_ir, s_pc4, imem(exp_pc), exp_pc + 32'd4); end
                exp_pc += 32'd4;
            end
        end
        n_checks++; if (fires !== 4) begin n_fail++; $display("FAIL bp_pops got %0d want 4", fires); end
        n_checks++; if (got !== 1'b1 || raddr !== 32'h10) begin n_fail++; $display("FAIL bp_resume got req=%b addr=%h want 1/00000010", got, raddr); end
    endtask

    task automatic test_redirect();
        logic found;
        int fires;
        do_reset();
        lat_min = 3; lat_max = 3; found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            tick(1'b0, 1'b0, 32'h0);
            if (s_req && s_addr == 32'h8) found = 1'b1;
        end
        n_checks++; if (found !== 1'b1) begin n_fail++; $display("FAIL redir_setup got no request to 8 want one"); end
        tick(1'b1, 1'b1, 32'h40);
        exp_pc = 32'h40;
        n_checks++; if (s_valid !== 1'b0) begin n_fail++; $display("FAIL redir_valid got %b want 0", s_valid); end
        n_checks++; if (s_req !== 1'b1 || s_ack !== 1'b0) begin n_fail++; $display("FAIL redir_pending got req=%b ack=%b want 1/0", s_req, s_ack); end
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            tick(1'b1, 1'b0, 32'h0);
            n_checks++; if (s_req !== 1'b1 || s_addr !== 32'h8 || s_valid !== 1'b0) begin n_fail++; $display("FAIL squash_hold got req=%b addr=%h valid=%b want 1/00000008/0", s_req, s_addr, s_valid); end
            if (s_ack) found = 1'b1;
        end
        tick(1'b1, 1'b0, 32'h0);
        n_checks++; if (s_addr !== 32'h40 || s_valid !== 1'b0) begin n_fail++; $display("FAIL redir_target got addr=%h valid=%b want 00000040/0", s_addr, s_valid); end
        fires = 0;
        for (int i = 0; i < 40 && fires < 3; i++) begin
            tick(1'b1, 1'b0, 32'h0);
            if (fire) begin
                fires++;
                n_checks++; if (s_ir !== imem(exp_pc) || s_pc4 !== exp_pc + 32'd4) begin n_fail++; $display("FAIL redir_data got %h/%h want %h/%h", s_ir, s_pc4, imem(exp_pc), exp_pc + 32'd4); end
                exp_pc += 32'd4;
            end
        end
        n_checks++; if (fires !== 3) begin n_fail++; $display("FAIL redir_stream got %0d words want 3", fires); end
    endtask

    task automatic test_halt();
        int acks, fires;
        logic rdy;
        do_reset();
        spec_addr = 32'hC; spec_word = 32'hFC00_0000;
        lat_min = 0; lat_max = 2; acks = 0; fires = 0;
        for (int i = 0; i < 70; i++) begin
            rdy = (i >= 60) ? 1'b1 : 1'($urandom_range(0, 1));
            tick(rdy, 1'b0, 32'h0);
            if (s_ack) acks++;
            if (s_halted) begin
                n_checks++; if (s_req !== 1'b0) begin n_fail++; $display("FAIL halt_req cyc %0d got %b want 0", i, s_req); end
            end
            if (fire) begin
                fires++;
                n_checks++; if (s_ir !== imem(exp_pc) || s_pc4 !== exp_pc + 32'd4) begin n_fail++; $display("FAIL halt_data got %h/%h want %h/%h", s_ir, s_pc4, imem(exp_pc), exp_pc + 32'd4); end
                exp_pc += 32'd4;
            end
        end
        n_checks++; if (acks !== 4) begin n_fail++; $display("FAIL halt_acks got %0d want 4", acks); end
        n_checks++; if (fires !== 4) begin n_fail++; $display("FAIL halt_drain got %0d want 4", fires); end
        n_checks++; if (s_halted !== 1'b1) begin n_fail++; $display("FAIL halt_flag got %b want 1", s_halted); end
        spec_addr = 32'h1;
        tick(1'b1, 1'b1, 32'h0);
        exp_pc = 32'h0;
        tick(1'b1, 1'b0, 32'h0);
        n_checks++; if (s_halted !== 1'b0 || s_req !== 1'b1 || s_addr !== 32'h0) begin n_fail++; $display("FAIL halt_exit got halted=%b req=%b addr=%h want 0/1/00000000", s_halted, s_req, s_addr); end
    endtask

    task automatic test_reset_mid();
        int acks;
        do_reset();
        lat_min = 2; lat_max = 2; acks = 0;
        for (int i = 0; i < 30 && acks < 2; i++) begin
            tick(1'b0, 1'b0, 32'h0);
            if (s_ack) acks++;
        end
        @(negedge clk); #1;
        n_checks++; if (id_valid !== 1'b1) begin n_fail++; $display("FAIL rstmid_queued got valid=%b want 1", id_valid); end
        rst = 1'b1;
        #1;
        n_checks++; if (mem_req !== 1'b0 || id_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_drop got req=%b valid=%b want 0/0", mem_req, id_valid); end
        @(negedge clk); #1;
        rst = 1'b0; exp_pc = 32'h0;
        tick(1'b0, 1'b0, 32'h0);
        n_checks++; if (s_req !== 1'b1 || s_addr !== 32'h0 || s_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_restart got req=%b addr=%h valid=%b want 1/00000000/0", s_req, s_addr, s_valid); end
    endtask

    task automatic test_random();
        logic rdy, rd, prev_pend;
        logic [31:0] rpc, prev_addr;
        do_reset();
        lat_min = 0; lat_max = 3; prev_pend = 1'b0; prev_addr = 32'h0;
        for (int i = 0; i < 600; i++) begin
            rdy = ($urandom_range(0, 3) != 0);
            rd  = ($urandom_range(0, 15) == 0);
            rpc = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF4 : ($urandom & 32'hFFFF_FFFC);
            tick(rdy, rd, rpc);
            if (prev_pend) begin
                n_checks++; if (s_req !== 1'b1 || s_addr !== prev_addr) begin n_fail++; $display("FAIL rnd_req_stable cyc %0d got req=%b addr=%h want 1/%h", i, s_req, s_addr, prev_addr); end
            end
            if (rd) begin
                n_checks++; if (s_valid !== 1'b0) begin n_fail++; $display("FAIL rnd_redir_valid cyc %0d got %b want 0", i, s_valid); end
            end
            if (fire) begin
                n_checks++; if (s_ir !== imem(exp_pc) || s_pc4 !== exp_pc + 32'd4) begin n_fail++; $display("FAIL rnd_data cyc %0d got %h/%h want %h/%h", i, s_ir, s_pc4, imem(exp_pc), exp_pc + 32'd4); end
                exp_pc += 32'd4;
            end
            if (rd) exp_pc = rpc;
            prev_pend = s_req && !s_ack;
            prev_addr = s_addr;
        end
    endtask

    task automatic test_ack_latency();
        do_reset();
        spec_addr = 32'h0; spec_word = 32'h2008_0005;
        lat_min = 1; lat_max = 1;
        tick(1'b1, 1'b0, 32'h0);
        n_checks++; if (s_valid !== 1'b0 || s_ack !== 1'b0) begin n_fail++; $display("FAIL lat_idle got valid=%b ack=%b want 0/0", s_valid, s_ack); end
        tick(1'b1, 1'b0, 32'h0);
`ifdef FETCHQ_BYPASS_EN
        n_checks++; if (s_ack !== 1'b1 || s_valid !== 1'b1 || s_ir !== 32'h2008_0005 || s_pc4 !== 32'h4) begin n_fail++; $display("FAIL lat_bypass got ack=%b valid=%b ir=%h pc4=%h want 1/1/20080005/00000004", s_ack, s_valid, s_ir, s_pc4); end
        tick(1'b1, 1'b0, 32'h0);
        n_checks++; if (s_valid !== 1'b0) begin n_fail++; $display("FAIL lat_bypass_count got valid=%b want 0", s_valid); end
`else
        n_checks++; if (s_ack !== 1'b1 || s_valid !== 1'b0) begin n_fail++; $display("FAIL lat_ack got ack=%b valid=%b want 1/0", s_ack, s_valid); end
        tick(1'b1, 1'b0, 32'h0);
        n_checks++; if (s_valid !== 1'b1 || s_ir !== 32'h2008_0005 || s_pc4 !== 32'h4) begin n_fail++; $display("FAIL lat_enq got valid=%b ir=%h pc4=%h want 1/20080005/00000004", s_valid, s_ir, s_pc4); end
`endif
    endtask

    initial begin
        rst = 1'b1; redirect = 1'b0; redirect_pc = 32'h0; id_ready = 1'b0; exp_pc = 32'h0;
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect();
        test_halt();
        test_reset_mid();
        test_ack_latency();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
